// File: rtl/if_id_skid_if.sv
// Fetch-to-ID handshake bundle: fetch beat, ID head entry, stall and flush controls.
// The slave modport is the skid buffer; the master modport is the fetch/ID environment.
interface if_id_skid_if #(
   parameter int PC_WIDTH   = 64,
   parameter int INST_WIDTH = 32
);
   logic                  if_valid;
   logic [PC_WIDTH-1:0]   if_pc;
   logic [INST_WIDTH-1:0] if_inst;
   logic                  if_ready;
   logic                  id_stall;
   logic                  flush;
   logic                  id_valid;
   logic [PC_WIDTH-1:0]   id_pc;
   logic [INST_WIDTH-1:0] id_inst;

   modport master (
      output if_valid, if_pc, if_inst, id_stall, flush,
      input  if_ready, id_valid, id_pc, id_inst
   );

   modport slave (
      input  if_valid, if_pc, if_inst, id_stall, flush,
      output if_ready, id_valid, id_pc, id_inst
   );
endinterface

// File: rtl/if_id_skid.sv
// IF/ID skid buffer: holds {pc, inst} pairs while ID stalls and drops them all on flush.
// Latency 1 cycle, no bypass; if_ready depends on registered occupancy only, so fetch stalls when full.
module if_id_skid #(
   parameter int                    PC_WIDTH   = 64,
   parameter int                    INST_WIDTH = 32,
   parameter int                    DEPTH      = 2,
   parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h0000_0013,
   parameter int                    CNT_WIDTH  = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   if_id_skid_if.slave              bus,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [CNT_WIDTH-1:0]     stall_cnt
);
   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

   typedef struct packed {
      logic [PC_WIDTH-1:0]   pc;
      logic [INST_WIDTH-1:0] inst;
   } entry_t;

   entry_t           storage [DEPTH];
   entry_t           head;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count;
   logic             empty;
   logic             full;
   logic             push;
   logic             pop;
   logic             stall_hit;

   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);

   // Flush overrides everything: the beat offered alongside it is dropped.
   assign push      = bus.if_valid & ~full & ~bus.flush;
   assign pop       = ~empty & ~bus.id_stall & ~bus.flush;
   assign stall_hit = ~empty & bus.id_stall & ~bus.flush;

   assign head         = storage[rd_ptr];
   assign bus.if_ready = ~full;
   assign bus.id_valid = ~empty;
   assign bus.id_pc    = empty ? '0 : head.pc;
   assign bus.id_inst  = empty ? NOP_INST : head.inst;
   assign occupancy    = count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (bus.flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is left untouched by flush; the zeroed count already hides stale entries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
      end else if (push) begin
         storage[wr_ptr] <= '{pc: bus.if_pc, inst: bus.if_inst};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (stall_hit && !(&stall_cnt)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   a_count_bound : assert property (@(posedge clk) disable iff (!rst_n) count <= FULL_CNT);
   a_ptr_gap     : assert property (@(posedge clk) disable iff (!rst_n)
                                    (wr_ptr - rd_ptr) == count[PTR_W-1:0]);
   a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) full |-> !push);
endmodule
